pipeline_hazard_unit: RTL and testbench

- Parametrised hazard-detection and forwarding controller for the 5-stage pipelined MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers).
- Keeps its own shadow copy of destination/write/load info for the EX, MEM and WB stages.
- From that shadow state it drives IF/ID stall, IF/ID flush, ID/EX bubble and EX-operand forwarding selects, plus saturating stall/flush counters.
- Sits beside the pipeline registers in MIPS_Processor; the pipeline registers obey its outputs.

---
 rtl/pipeline_hazard_unit.sv | 173 +++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: hazard detection and EX-operand forwarding control for
// the 5-stage MIPS pipeline. The unit tracks its own copy of the EX/MEM/WB
// destination info and decides when IF/ID stalls, flushes, or ID/EX gets a bubble.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   id_*                  decoded fields of the instruction currently in ID
//   ex_redirect           EX resolved a taken branch/jump this cycle
//   stall_if_id           hold PC and IF/ID            (combinational)
//   flush_if_id           turn IF/ID into a NOP        (combinational)
//   bubble_id_ex          load a NOP into ID/EX        (combinational)
//   fwd_a, fwd_b          EX operand source: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_cycles          saturating count of stalled cycles (registered)
//   flush_count           saturating count of redirects      (registered)
module pipeline_hazard_unit #(
  parameter int unsigned REG_ADDR_W     = 5,
  parameter bit          FORWARDING     = 1'b1,
  parameter bit          REGFILE_BYPASS = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_redirect,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Producer info carried by every tracked stage.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } stage_t;

  // Source operands of the instruction in EX, needed to pick forwards.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  uses_rs;
    logic                  uses_rt;
  } src_t;

  stage_t ex_q, ex_d, mem_q, wb_q;
  src_t   ex_src_q, ex_src_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hit_ex, hit_mem, hit_wb;
  logic hazard;

  // True when stage s will write register r; $0 is never a real dependency.
  function automatic logic writes(input stage_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid & s.reg_write & (s.dest != '0) & (s.dest == r);
  endfunction

  // Does a stage produce one of the sources the ID instruction reads?
  always_comb begin
    hit_ex  = (id_uses_rs & writes(ex_q,  id_rs)) | (id_uses_rt & writes(ex_q,  id_rt));
    hit_mem = (id_uses_rs & writes(mem_q, id_rs)) | (id_uses_rt & writes(mem_q, id_rt));
    hit_wb  = (id_uses_rs & writes(wb_q,  id_rs)) | (id_uses_rt & writes(wb_q,  id_rt));
  end

  // With forwarding only a load in EX cannot be bypassed in time; without it
  // the ID instruction waits until every in-flight producer has retired.
  always_comb begin
    hazard = 1'b0;
    if (FORWARDING) begin
      hazard = ex_q.mem_read & hit_ex;
    end else begin
      hazard = hit_ex | hit_mem | (~REGFILE_BYPASS & hit_wb);
    end
    hazard = hazard & id_valid;
  end

  // Redirect beats a hazard: the stalled instruction is being squashed anyway.
  always_comb begin
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    if (reset) begin
      if (ex_redirect) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else begin
        stall_if_id  = hazard;
        bubble_id_ex = hazard;
      end
    end
  end

  // Forward selects; EX/MEM is the younger producer so it wins over MEM/WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (FORWARDING && reset && ex_q.valid) begin
      if (ex_src_q.uses_rs) begin
        if (writes(mem_q, ex_src_q.rs)) begin
          fwd_a = FWD_MEM;
        end else if (writes(wb_q, ex_src_q.rs)) begin
          fwd_a = FWD_WB;
        end
      end
      if (ex_src_q.uses_rt) begin
        if (writes(mem_q, ex_src_q.rt)) begin
          fwd_b = FWD_MEM;
        end else if (writes(wb_q, ex_src_q.rt)) begin
          fwd_b = FWD_WB;
        end
      end
    end
  end

  // Next EX record and saturating counters.
  always_comb begin
    ex_d        = ex_q;
    ex_d.valid  = 1'b0;
    ex_src_d    = ex_src_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_valid && !bubble_id_ex) begin
      ex_d     = '{valid: 1'b1, dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};
      ex_src_d = '{rs: id_rs, rt: id_rt, uses_rs: id_uses_rs, uses_rt: id_uses_rt};
    end
    if (stall_if_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ex_redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Stage shadow registers and counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_src_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      ex_src_q    <= ex_src_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: three configurations driven with the same
// ID stream (forwarding; stall-only with regfile bypass; stall-only without
// bypass and 2-bit counters) and compared each cycle against a reference model
// that reasons about producer distance in an in-flight instruction history.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic       ex_redirect;

  logic [2:0]  st, fl, bb;
  logic [1:0]  fa0, fa1, fa2, fb0, fb1, fb2;
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [1:0]  sc2, fc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_ADDR_W(5), .FORWARDING(1'b1), .REGFILE_BYPASS(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
    .stall_if_id(st[0]), .flush_if_id(fl[0]), .bubble_id_ex(bb[0]),
    .fwd_a(fa0), .fwd_b(fb0), .stall_cycles(sc0), .flush_count(fc0));

  pipeline_hazard_unit #(.REG_ADDR_W(5), .FORWARDING(1'b0), .REGFILE_BYPASS(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
    .stall_if_id(st[1]), .flush_if_id(fl[1]), .bubble_id_ex(bb[1]),
    .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(sc1), .flush_count(fc1));

  pipeline_hazard_unit #(.REG_ADDR_W(5), .FORWARDING(1'b0), .REGFILE_BYPASS(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
    .stall_if_id(st[2]), .flush_if_id(fl[2]), .bubble_id_ex(bb[2]),
    .fwd_a(fa2), .fwd_b(fb2), .stall_cycles(sc2), .flush_count(fc2));

  // ---------------- reference model ----------------
  typedef struct {
    bit       valid;
    bit [4:0] dest, rs, rt;
    bit       rw, mr, urs, urt;
  } ins_t;

  typedef struct packed {
    bit       stall, flush, bubble;
    bit [1:0] fa, fb;
  } exp_t;

  // hist[k][0] = instruction now in EX, [1] = MEM, [2] = WB
  ins_t    hist [3][3];
  longint  cnt_st [3];
  longint  cnt_fl [3];

  function automatic bit cfg_fwd(int k); return (k == 0); endfunction
  function automatic bit cfg_byp(int k); return (k != 2); endfunction
  function automatic int cfg_w(int k);   return (k == 2) ? 2 : 16; endfunction

  // How many stages ahead of EX the youngest writer of r sits (9 = none).
  function automatic int prod_dist(int k, bit [4:0] r, int from);
    for (int i = from; i < 3; i++) begin
      if (r != 0 && hist[k][i].valid && hist[k][i].rw && hist[k][i].dest == r) return i;
    end
    return 9;
  endfunction

  function automatic bit [1:0] fwd_code(int d, bit used);
    if (!used) return 2'b00;
    if (d == 1) return 2'b10;
    if (d == 2) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_out(int k);
    exp_t e;
    bit   haz;
    int   lim;
    e   = '0;
    haz = 1'b0;
    if (!reset) return e;
    // stall-only mode waits while the producer is within reach of ID's read
    lim = cfg_byp(k) ? 1 : 2;
    if (id_valid) begin
      for (int s = 0; s < 2; s++) begin
        bit       u;
        bit [4:0] r;
        int       d;
        u = (s == 1) ? id_uses_rt : id_uses_rs;
        r = (s == 1) ? id_rt : id_rs;
        d = prod_dist(k, r, 0);
        if (u) begin
          if (cfg_fwd(k)) haz |= (d == 0 && hist[k][0].mr);
          else            haz |= (d <= lim);
        end
      end
    end
    if (ex_redirect) begin
      e.flush  = 1'b1;
      e.bubble = 1'b1;
    end else begin
      e.stall  = haz;
      e.bubble = haz;
    end
    if (cfg_fwd(k) && hist[k][0].valid) begin
      e.fa = fwd_code(prod_dist(k, hist[k][0].rs, 1), hist[k][0].urs);
      e.fb = fwd_code(prod_dist(k, hist[k][0].rt, 1), hist[k][0].urt);
    end
    return e;
  endfunction

  function automatic exp_t dut_out(int k);
    exp_t g;
    g.stall  = st[k];
    g.flush  = fl[k];
    g.bubble = bb[k];
    case (k)
      0:       begin g.fa = fa0; g.fb = fb0; end
      1:       begin g.fa = fa1; g.fb = fb1; end
      default: begin g.fa = fa2; g.fb = fb2; end
    endcase
    return g;
  endfunction

  function automatic longint got_sc(int k);
    case (k)
      0:       return longint'(sc0);
      1:       return longint'(sc1);
      default: return longint'(sc2);
    endcase
  endfunction

  function automatic longint got_fc(int k);
    case (k)
      0:       return longint'(fc0);
      1:       return longint'(fc1);
      default: return longint'(fc2);
    endcase
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output of every configuration against the model.
  task automatic sample();
    exp_t e, g;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e = model_out(k);
      g = dut_out(k);
      check_eq($sformatf("c%0d_stall",  k), longint'(g.stall),  longint'(e.stall));
      check_eq($sformatf("c%0d_flush",  k), longint'(g.flush),  longint'(e.flush));
      check_eq($sformatf("c%0d_bubble", k), longint'(g.bubble), longint'(e.bubble));
      check_eq($sformatf("c%0d_fwd_a",  k), longint'(g.fa),     longint'(e.fa));
      check_eq($sformatf("c%0d_fwd_b",  k), longint'(g.fb),     longint'(e.fb));
      check_eq($sformatf("c%0d_stall_cycles", k), got_sc(k), cnt_st[k]);
      check_eq($sformatf("c%0d_flush_count",  k), got_fc(k), cnt_fl[k]);
    end
  endtask

  // Advance the model by one clock with the current inputs, then the DUTs.
  task automatic advance();
    exp_t   e;
    longint mx;
    for (int k = 0; k < 3; k++) begin
      e  = model_out(k);
      mx = (longint'(1) << cfg_w(k)) - 1;
      if (!reset) begin
        for (int i = 0; i < 3; i++) hist[k][i] = '{default: 0};
        cnt_st[k] = 0;
        cnt_fl[k] = 0;
      end else begin
        if (e.stall && cnt_st[k] < mx) cnt_st[k]++;
        if (ex_redirect && cnt_fl[k] < mx) cnt_fl[k]++;
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = '{valid: id_valid && !e.bubble, dest: id_dest, rs: id_rs, rt: id_rt,
                       rw: id_reg_write, mr: id_mem_read, urs: id_uses_rs, urt: id_uses_rt};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                        input bit urt, input bit [4:0] dest, input bit rw, input bit mr);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_dest      = dest;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) hist[k][i] = '{default: 0};
      cnt_st[k] = 0;
      cnt_fl[k] = 0;
    end
    reset       = 1'b0;
    ex_redirect = 1'b0;

    // reset held with a valid, hazard-looking ID instruction
    set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc();
    cyc();
    reset = 1'b1;
    nop();
    sample();
    check_eq("rst_fwd_a", longint'(fa0), 0);
    check_eq("rst_fwd_b", longint'(fb0), 0);
    advance();

    // load-use: lw $8 ; add $9,$8,$10
    set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    sample();
    check_eq("lu_stall", longint'(st[0]), 1);
    check_eq("lu_bubble", longint'(bb[0]), 1);
    advance();
    sample();
    check_eq("lu_release", longint'(st[0]), 0);
    advance();
    nop();
    sample();
    check_eq("lu_fwd_a", longint'(fa0), 1);
    check_eq("lu_stall_cycles", longint'(sc0), 1);
    advance();

    // back-to-back ALU: add $8 ; sub $11,$8,$8 ; xor $13,$8,$0
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    sample();
    check_eq("alu_no_stall", longint'(st[0]), 0);
    advance();
    set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    sample();
    check_eq("alu_fwd_a_mem", longint'(fa0), 2);
    check_eq("alu_fwd_b_mem", longint'(fb0), 2);
    advance();
    nop();
    sample();
    check_eq("alu_fwd_a_wb", longint'(fa0), 1);
    check_eq("alu_fwd_b_r0", longint'(fb0), 0);
    advance();

    // double write: youngest producer wins
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc();
    cyc();
    set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    cyc();
    nop();
    sample();
    check_eq("dw_fwd_a", longint'(fa0), 2);
    advance();

    // writes to $0 never forward
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc();
    nop();
    sample();
    check_eq("r0_fwd_a", longint'(fa0), 0);
    check_eq("r0_fwd_b", longint'(fb0), 0);
    advance();

    // redirect in the same cycle as a load-use hazard
    set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    sample();
    check_eq("rd_flush", longint'(fl[0]), 1);
    check_eq("rd_bubble", longint'(bb[0]), 1);
    check_eq("rd_stall", longint'(st[0]), 0);
    advance();
    ex_redirect = 1'b0;
    nop();
    sample();
    check_eq("rd_flush_count", longint'(fc0), 1);
    check_eq("rd_stall_cycles", longint'(sc0), 1);
    advance();

    // random traffic over a small register window to provoke dependencies
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 39) != 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      set_id(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      cyc();
    end

    // stall-only chains: add $8 ; add $9,$8 (x4) ; add $10,$9 (x4)
    reset       = 1'b0;
    ex_redirect = 1'b0;
    nop();
    cyc();
    reset = 1'b1;
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    repeat (4) cyc();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    repeat (4) cyc();
    nop();
    sample();
    check_eq("sat_stall_cycles_w2", longint'(sc2), 3);
    check_eq("nf_stall_cycles", longint'(sc1), 4);
    check_eq("fw_stall_cycles", longint'(sc0), 0);
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
